// File: rtl/color_command_writer_pkg.sv
// Shared Color_Manager widths, header constant and writer state encoding.
// Checksum framing is enabled by defining CMD_CHECKSUM_EN.
package color_command_writer_pkg;

  localparam int CMD_ADDR_W  = 10;
  localparam int CMD_DATA_W  = 14;
  localparam int CMD_ERR_W   = 8;
  localparam int CMD_TIMEOUT = 1000;

  localparam logic [7:0] CMD_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_CSUM,
    ST_ISSUE
  } cmd_state_e;

endpackage

// File: rtl/color_command_writer_if.sv
// Byte stream in, colour-entry write out, plus error/status outputs.
// master = writer side, slave = environment side.
interface color_command_writer_if
  import color_command_writer_pkg::*;
#(
  parameter int C_ADDR_WIDTH  = CMD_ADDR_W,
  parameter int C_DATA_WIDTH  = CMD_DATA_W,
  parameter int ERR_CNT_WIDTH = CMD_ERR_W
);

  logic [7:0]               Byte_In;
  logic                     Byte_Valid;
  logic                     Byte_Rdy;
  logic [C_ADDR_WIDTH-1:0]  C_Addr;
  logic [C_DATA_WIDTH-1:0]  C_Data;
  logic                     C_Valid;
  logic                     C_Rdy;
  logic                     Frame_Error;
  logic [ERR_CNT_WIDTH-1:0] Error_Count;
  logic                     Busy;

  modport master (
    input  Byte_In, Byte_Valid, C_Rdy,
    output Byte_Rdy, C_Addr, C_Data, C_Valid,
    output Frame_Error, Error_Count, Busy
  );

  modport slave (
    output Byte_In, Byte_Valid, C_Rdy,
    input  Byte_Rdy, C_Addr, C_Data, C_Valid,
    input  Frame_Error, Error_Count, Busy
  );

endinterface

// File: rtl/color_command_writer_cmd_timeout_counter.sv
// Inter-byte idle counter; expired flags the edge on which it reaches
// TIMEOUT_CYCLES-1. Requires TIMEOUT_CYCLES >= 2.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && !clear) cnt_d = cnt_q + CW'(1);
  end

  assign expired = enable && !clear && (cnt_q == LIM);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/color_command_writer.sv
// Parses A5-headed command frames into Color_Manager entry writes.
// CMD_CHECKSUM_EN adds a trailing XOR checksum byte and its error path.
module color_command_writer
  import color_command_writer_pkg::*;
#(
  parameter int C_ADDR_WIDTH   = CMD_ADDR_W,
  parameter int C_DATA_WIDTH   = CMD_DATA_W,
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT,
  parameter int ERR_CNT_WIDTH  = CMD_ERR_W
) (
  input logic                    Clk,
  input logic                    Rst,
  color_command_writer_if.master bus
);

  cmd_state_e state_q, state_d;

  logic [7:0] addr_h_q, addr_h_d;
  logic [7:0] addr_l_q, addr_l_d;
  logic [7:0] data_h_q, data_h_d;
  logic [7:0] data_l_q, data_l_d;

  logic                     c_valid_q, c_valid_d;
  logic [C_ADDR_WIDTH-1:0]  c_addr_q, c_addr_d;
  logic [C_DATA_WIDTH-1:0]  c_data_q, c_data_d;
  logic                     frame_error_q, frame_error_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic cnt_en;
  logic expired;
  logic frame_done;

`ifdef CMD_CHECKSUM_EN
  logic csum_ok;
  assign csum_ok =
    (addr_h_q ^ addr_l_q ^ data_h_q ^ data_l_q) == bus.Byte_In;
`endif

  assign accept = bus.Byte_Valid && bus.Byte_Rdy;
  assign cnt_en = (state_q != ST_IDLE) && (state_q != ST_ISSUE);

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (accept),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      addr_h_q      <= '0;
      addr_l_q      <= '0;
      data_h_q      <= '0;
      data_l_q      <= '0;
      c_valid_q     <= 1'b0;
      c_addr_q      <= '0;
      c_data_q      <= '0;
      frame_error_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_h_q      <= addr_h_d;
      addr_l_q      <= addr_l_d;
      data_h_q      <= data_h_d;
      data_l_q      <= data_l_d;
      c_valid_q     <= c_valid_d;
      c_addr_q      <= c_addr_d;
      c_data_q      <= c_data_d;
      frame_error_q <= frame_error_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_error_d = 1'b0;
    frame_done    = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (accept && bus.Byte_In == CMD_HDR)
          state_d = ST_ADDR_H;
      ST_ADDR_H: if (accept) state_d = ST_ADDR_L;
      ST_ADDR_L: if (accept) state_d = ST_DATA_H;
      ST_DATA_H: if (accept) state_d = ST_DATA_L;
`ifdef CMD_CHECKSUM_EN
      ST_DATA_L: if (accept) state_d = ST_CSUM;
      ST_CSUM:
        if (accept) begin
          if (csum_ok) begin
            state_d    = ST_ISSUE;
            frame_done = 1'b1;
          end else begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
          end
        end
`else
      ST_DATA_L:
        if (accept) begin
          state_d    = ST_ISSUE;
          frame_done = 1'b1;
        end
`endif
      ST_ISSUE: if (bus.C_Rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // a byte landing on the expiry edge keeps the frame alive
    if (expired && !accept) begin
      state_d       = ST_IDLE;
      frame_error_d = 1'b1;
    end
  end

  always_comb begin
    addr_h_d  = addr_h_q;
    addr_l_d  = addr_l_q;
    data_h_d  = data_h_q;
    data_l_d  = data_l_q;
    c_valid_d = c_valid_q;
    c_addr_d  = c_addr_q;
    c_data_d  = c_data_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      unique case (state_q)
        ST_ADDR_H: addr_h_d = bus.Byte_In;
        ST_ADDR_L: addr_l_d = bus.Byte_In;
        ST_DATA_H: data_h_d = bus.Byte_In;
        ST_DATA_L: data_l_d = bus.Byte_In;
        default:   ;
      endcase
    end
    if (frame_done) begin
      c_valid_d = 1'b1;
      c_addr_d  = C_ADDR_WIDTH'({addr_h_q, addr_l_q});
      c_data_d  = C_DATA_WIDTH'({data_h_q, data_l_d});
    end else if (state_q == ST_ISSUE && bus.C_Rdy) begin
      c_valid_d = 1'b0;
    end
    if (frame_error_d && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_comb begin
    bus.Byte_Rdy = !Rst && (state_q != ST_ISSUE);
    bus.Busy     = state_q != ST_IDLE;
  end

  assign bus.C_Valid     = c_valid_q;
  assign bus.C_Addr      = c_addr_q;
  assign bus.C_Data      = c_data_q;
  assign bus.Frame_Error = frame_error_q;
  assign bus.Error_Count = err_cnt_q;

endmodule

// File: tb/tb_color_command_writer.sv
// Scoreboard bench for color_command_writer (short timeout for speed).
// Builds with or without CMD_CHECKSUM_EN.
module tb_color_command_writer;
  import color_command_writer_pkg::*;

  localparam int T = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  color_command_writer_if bus ();

  color_command_writer #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [13:0] d;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t e;
  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_fe    = 0;
  int exp_err = 0;
  int exp_fe  = 0;
  int k_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && bus.Frame_Error) n_fe++;
    if (!Rst && bus.C_Valid && bus.C_Rdy) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("xfer_unexp", 32'(bus.C_Valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_addr", 32'(bus.C_Addr), 32'(e.a));
        chk("xfer_data", 32'(bus.C_Data), 32'(e.d));
      end
    end
  end

  // called and returns one delta after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.Byte_In    = b;
    bus.Byte_Valid = 1'b1;
    @(negedge Clk);
    while (!bus.Byte_Rdy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) chk("byte_rdy_wait", 32'(bus.Byte_Rdy), 1);
    @(posedge Clk);
    #1;
    bus.Byte_Valid = 1'b0;
  endtask

  task automatic send_body(input logic [15:0] a,
                           input logic [15:0] d,
                           input bit push);
    logic [7:0] cs;
    cs = a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0];
    if (push) exp_q.push_back({a[9:0], d[13:0]});
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(d[15:8]);
`ifdef CMD_CHECKSUM_EN
    send_byte(d[7:0]);
    send_byte(cs);
`else
    send_byte(d[7:0] ^ cs ^ cs);
`endif
  endtask

  task automatic send_frame(input logic [15:0] a,
                            input logic [15:0] d,
                            input bit push);
    send_byte(CMD_HDR);
    send_body(a, d, push);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((bus.Busy || bus.C_Valid) && n < 4 * T);
    if (bus.Busy || bus.C_Valid) chk("idle_wait", 32'(bus.Busy), 0);
    @(posedge Clk);
    #1;
  endtask

  function automatic void count_err();
    exp_fe++;
    if (exp_err < 255) exp_err++;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Byte_In    = '0;
    bus.Byte_Valid = 1'b0;
    bus.C_Rdy      = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_byte_rdy", 32'(bus.Byte_Rdy), 0);
    chk("rst_c_valid", 32'(bus.C_Valid), 0);
    chk("rst_c_addr", 32'(bus.C_Addr), 0);
    chk("rst_c_data", 32'(bus.C_Data), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_fe", 32'(bus.Frame_Error), 0);
    chk("rst_err", 32'(bus.Error_Count), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // single-cycle transfer with C_Rdy already high
    bus.C_Rdy = 1'b1;
    send_frame(16'h03E8, 16'h0FFF, 1'b1);
    @(negedge Clk);
    chk("t1_valid", 32'(bus.C_Valid), 1);
    chk("t1_addr", 32'(bus.C_Addr), 1000);
    chk("t1_data", 32'(bus.C_Data), 32'h0FFF);
    @(negedge Clk);
    chk("t1_drop", 32'(bus.C_Valid), 0);
    chk("t1_busy", 32'(bus.Busy), 0);
    @(posedge Clk);
    #1;

    // back-pressure from Color_Manager
    bus.C_Rdy = 1'b0;
    send_frame(16'h03E8, 16'h2F1F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("t2_hold_valid", 32'(bus.C_Valid), 1);
      chk("t2_hold_data", 32'(bus.C_Data), 32'h2F1F);
      chk("t2_byte_rdy", 32'(bus.Byte_Rdy), 0);
    end
    @(posedge Clk);
    #1;
    bus.C_Rdy = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("t2_drop", 32'(bus.C_Valid), 0);
    @(posedge Clk);
    #1;

    // reset while waiting in ISSUE aborts the entry
    bus.C_Rdy = 1'b0;
    send_frame(16'h0123, 16'h0456, 1'b0);
    @(negedge Clk);
    chk("t3_pending", 32'(bus.C_Valid), 1);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("t3_valid", 32'(bus.C_Valid), 0);
    chk("t3_err", 32'(bus.Error_Count), 0);
    chk("t3_busy", 32'(bus.Busy), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    bus.C_Rdy = 1'b1;

`ifdef CMD_CHECKSUM_EN
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'hE8);
    send_byte(8'h0F);
    send_byte(8'hFF);
    send_byte(8'h00);
    count_err();
    @(negedge Clk);
    chk("t4_valid", 32'(bus.C_Valid), 0);
    chk("t4_fe", 32'(bus.Frame_Error), 1);
    @(negedge Clk);
    chk("t4_fe_pulse", 32'(bus.Frame_Error), 0);
    chk("t4_err", 32'(bus.Error_Count), 1);
    chk("t4_busy", 32'(bus.Busy), 0);
    @(posedge Clk);
    #1;
`endif

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h03);
    k_seen = -1;
    for (int k = 0; k < T + 4; k++) begin
      @(negedge Clk);
      if (bus.Frame_Error && k_seen < 0) k_seen = k;
    end
    count_err();
    chk("t5_to_cycle", 32'(k_seen), T - 1);
    chk("t5_err", 32'(bus.Error_Count), 32'(exp_err));
    chk("t5_busy", 32'(bus.Busy), 0);
    @(posedge Clk);
    #1;
    send_frame(16'h0055, 16'h1234, 1'b1);
    wait_idle();

    // byte on the expiry edge keeps the frame alive
    send_byte(CMD_HDR);
    repeat (T - 2) @(posedge Clk);
    #1;
    send_body(16'h02AA, 16'h3C5A, 1'b1);
    wait_idle();
    chk("t6_err", 32'(bus.Error_Count), 32'(exp_err));

    // junk before the header is silently dropped
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    chk("t7_busy", 32'(bus.Busy), 0);
    send_frame(16'h0301, 16'h00A5, 1'b1);
    wait_idle();
    chk("t7_err", 32'(bus.Error_Count), 32'(exp_err));

    // saturation of the error counter
    for (int f = 0; f < 256; f++) begin
      send_byte(CMD_HDR);
      wait_idle();
      count_err();
    end
    chk("t8_err_sat", 32'(bus.Error_Count), 255);
    chk("t8_fe_pulses", 32'(n_fe), 32'(exp_fe));
    chk("xfer_count", 32'(n_xfer), 5);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_command_writer.md
COLOR_COMMAND_WRITER -- requirements
Module: color_command_writer

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 10, meaning the colour-entry address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 14, meaning the colour-entry data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum number of idle cycles allowed between bytes within one frame.
REQ-004 SHALL have parameter ERR_CNT_WIDTH, default 8, meaning the width of the error counter.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port Byte_In, input, 8 bits: command byte from the upstream receiver.
REQ-008 SHALL have port Byte_Valid, input, 1 bit: Byte_In is valid.
REQ-009 SHALL have port Byte_Rdy, output, 1 bit: a byte is accepted on any edge where Byte_Valid && Byte_Rdy.
REQ-010 SHALL have port C_Addr, output, C_ADDR_WIDTH bits: colour-entry address sent to Color_Manager.
REQ-011 SHALL have port C_Data, output, C_DATA_WIDTH bits: colour-entry data sent to Color_Manager.
REQ-012 SHALL have port C_Valid, output, 1 bit: C_Addr and C_Data are valid.
REQ-013 SHALL have port C_Rdy, input, 1 bit: Color_Manager accepts the entry on any edge where C_Valid && C_Rdy.
REQ-014 SHALL have port Frame_Error, output, 1 bit: one-cycle pulse on a frame error.
REQ-015 SHALL have port Error_Count, output, ERR_CNT_WIDTH bits: saturating count of frame errors.
REQ-016 SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, CSUM and ISSUE.
REQ-018 SHALL hold Byte_Rdy=1 in every state except ISSUE, and Byte_Rdy=0 in ISSUE.
REQ-019 SHALL, in IDLE, move to ADDR_H on acceptance of the header byte 0xA5 and silently discard any other byte.
REQ-020 SHALL advance ADDR_H->ADDR_L->DATA_H->DATA_L->CSUM, one state per accepted byte.
REQ-021 SHALL treat a 0xA5 byte received after the header as payload; there is no mid-frame resynchronisation.
REQ-022 SHALL form C_Addr from the low C_ADDR_WIDTH bits of {ADDR_H, ADDR_L} and C_Data from the low C_DATA_WIDTH bits of {DATA_H, DATA_L}.
REQ-023 SHALL, in CSUM, compare the accepted byte with the XOR of the four payload bytes: on a match go to ISSUE; on a mismatch go to IDLE, pulse Frame_Error and do not assert C_Valid.
REQ-024 SHALL register C_Valid high on the edge after the final frame byte is accepted.
REQ-025 SHALL keep C_Valid, C_Addr and C_Data stable until the edge where C_Valid && C_Rdy, then drive C_Valid=0 and return to IDLE.
REQ-026 SHALL complete the transfer on the first ISSUE cycle if C_Rdy is already high in that cycle.
REQ-027 SHALL, in ADDR_H through CSUM, reset the idle counter on every accepted byte and otherwise increment it.
REQ-028 SHALL, when the idle counter reaches TIMEOUT_CYCLES-1, go to IDLE and pulse Frame_Error.
REQ-029 SHALL keep the idle counter cleared in IDLE and ISSUE; ISSUE has no timeout.
REQ-030 SHALL increment Error_Count on each Frame_Error pulse and saturate it at all-ones.
REQ-031 SHALL, when a timeout and a byte acceptance occur on the same edge, let the acceptance win and not flag an error.

Reset
REQ-032 SHALL, on Clk while Rst=1: state=IDLE, C_Valid=0, C_Addr=0, C_Data=0, Frame_Error=0, Error_Count=0, Busy=0, idle counter=0, payload registers=0.
REQ-033 SHALL abort any pending frame or unacknowledged C_Valid on reset, with no transfer and no error counted.
REQ-034 SHALL hold Byte_Rdy=0 while Rst=1.

Configuration
REQ-035 SHALL, with CMD_CHECKSUM_EN defined, use the 6-byte frame (header, 4 payload bytes, checksum) and implement the CSUM state and error path.
REQ-036 SHALL, with CMD_CHECKSUM_EN undefined, use a 5-byte frame that goes DATA_L->ISSUE, omit the CSUM state and XOR logic, and allow frame errors to arise only from timeout.

Structure
REQ-037 SHALL take the state encoding, the header constant 0xA5 and the default widths from the shared Color_Manager width/constants package.
REQ-038 SHALL place the idle-timeout counter in sub-module cmd_timeout_counter (inputs clear/enable, output expired).

Verification
REQ-039 SHALL verify that bytes A5 03 E8 0F FF 1B with C_Rdy=1 produce C_Valid one cycle after 1B, with C_Addr=1000 and C_Data=14'h0FFF, and a single-cycle transfer.
REQ-040 SHALL verify that bytes A5 03 E8 2F 1F DB with C_Rdy held 0 for 5 cycles keep C_Valid high and C_Data=14'h2F1F stable, with Byte_Rdy=0, until C_Rdy rises.
REQ-041 SHALL verify that a bad checksum (A5 03 E8 0F FF 00) produces no C_Valid, one Frame_Error pulse, Error_Count=1, and a return to IDLE.
REQ-042 SHALL verify that A5 03 followed by silence produces Frame_Error at cycle TIMEOUT_CYCLES-1 after byte 03, and that a following valid frame is then processed normally.
REQ-043 SHALL verify that junk bytes 00 FF 12 before A5 are discarded without error, and that 256 bad frames leave Error_Count at 255.
REQ-044 SHALL verify that asserting Rst during ISSUE drops C_Valid on the next edge and leaves Error_Count unchanged.
